constraint_search_ctrl: RTL and testbench
=========================================

Name: constraint_search_ctrl

Overview:
- Sequencer that drives a generated combinational constraint checker: packed variable vector in, 1-bit satisfied flag `x` out.
- Produces pseudo-random candidate vectors from a seeded LFSR, holds each for the checker's settle latency and samples the verdict.
- Hands satisfying vectors to a downstream consumer over a valid/ready interface.
- Sits between the solver's test harness and any generated checker module.

Parameters:
- VEC_W, 64: total packed width of all checker variables (>=1).
- CHK_LAT, 0: extra cycles the checker output needs to settle (0 = purely combinational checker).
- TRY_W, 16: width of try counter and max_tries.
- SOL_W, 8: width of solution counter and sol_target.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin search; sampled in IDLE only
- abort  in  1  synchronous cancel, any state
- seed  in  32  LFSR seed, captured on accepted start
- max_tries  in  TRY_W  candidate budget; 0 = unlimited
- sol_target  in  SOL_W  solutions wanted; 0 treated as 1
- cand_vec  out  VEC_W  candidate to checker
- cand_valid  out  1  cand_vec stable, checker being evaluated
- chk_result  in  1  checker output x
- sol_valid  out  1  satisfying vector presented
- sol_vec  out  VEC_W  satisfying vector
- sol_ready  in  1  consumer accepts sol_vec
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at search end
- found  out  1  last search reached sol_target; held until next start
- timeout  out  1  last search exhausted max_tries; held until next start
- tries_cnt  out  TRY_W  candidates evaluated in current/last search
- sol_cnt  out  SOL_W  solutions accepted in current/last search

Behaviour:
- Reset values: all outputs 0, cand_vec 0, LFSR 32'h1, state IDLE.
- LFSR: 32-bit Galois right-shift, next = (l>>1) ^ (l[0] ? 32'h80200003 : 0).
  - Seed 0 is loaded as 32'h1.
- WORDS = ceil(VEC_W/32).
- States: IDLE, GEN, WAIT, SOL, FIN.
- IDLE + start:
  - load LFSR from seed.
  - clear tries_cnt, sol_cnt, found, timeout.
  - go to GEN.
- GEN (WORDS cycles), each cycle:
  - LFSR steps.
  - cand_vec <= {cand_vec, lfsr_next} truncated to low VEC_W bits, so the first word ends in the MSBs.
  - After the last GEN cycle, go to WAIT.
- WAIT (CHK_LAT+1 cycles):
  - cand_valid=1, cand_vec frozen.
  - chk_result sampled on the final WAIT edge only.
  - tries_cnt increments on that edge.
- Per-try latency: WORDS+CHK_LAT+1 cycles from GEN entry to verdict.
- Verdict 1: go to SOL.
- Verdict 0:
  - if max_tries!=0 and tries_cnt (post-increment) == max_tries: go to FIN with timeout=1.
  - else go to GEN.
- SOL:
  - sol_valid=1, sol_vec=cand_vec, both held stable until sol_ready.
  - On the handshake edge sol_cnt increments.
  - If sol_cnt (post-increment) == max(sol_target,1): go to FIN with found=1.
  - Else, if the try budget is exhausted: go to FIN with timeout=1.
  - Otherwise go to GEN.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in GEN/WAIT/SOL/FIN.
- start while busy: ignored.
- abort:
  - next state IDLE, sol_valid/cand_valid drop next cycle.
  - no done pulse; found=timeout=0.
  - counters keep their values.
  - abort has priority over all other transitions, including a same-cycle sol handshake (the solution counts if sol_ready was high).
- Counters saturate at all-ones, no wrap; a saturated tries_cnt never matches a smaller max_tries.
- Async reset mid-search: immediate return to reset values.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> every output 0 immediately, state IDLE, and a subsequent start works.
- VEC_W=32, CHK_LAT=0, seed=1, chk_result tied 1, sol_ready=1, sol_target=1 -> sol_vec=32'h80200003, sol_valid 2 cycles after start edge, done pulse one cycle later, found=1, tries_cnt=1.
- VEC_W=64, CHK_LAT=2, seed=0, chk_result tied 1 -> sol_vec=64'h80200003_C0300002, sol_valid exactly 5 cycles after start edge.
- chk_result tied 0, VEC_W=64, CHK_LAT=2, max_tries=4 -> done at cycle 21, timeout=1, found=0, tries_cnt=4, sol_valid never high.
- chk_result tied 1, sol_target=3, sol_ready low 10 cycles per solution -> sol_vec stable while stalled, three distinct solutions, sol_cnt=3, found=1.
- abort during SOL with sol_ready=0 -> IDLE next cycle, no done, sol_cnt unchanged; abort with sol_ready=1 same cycle -> sol_cnt+1, still no done.

Source files
------------

// File: rtl/constraint_search_ctrl.sv
// Random-search sequencer for a generated combinational constraint checker.
// Seeded Galois LFSR builds candidates, waits out checker latency, and streams out satisfying vectors.
module constraint_search_ctrl #(
  parameter int unsigned VEC_W   = 64,
  parameter int unsigned CHK_LAT = 0,
  parameter int unsigned TRY_W   = 16,
  parameter int unsigned SOL_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [TRY_W-1:0] max_tries,
  input  logic [SOL_W-1:0] sol_target,
  output logic [VEC_W-1:0] cand_vec,
  output logic             cand_valid,
  input  logic             chk_result,
  output logic             sol_valid,
  output logic [VEC_W-1:0] sol_vec,
  input  logic             sol_ready,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timeout,
  output logic [TRY_W-1:0] tries_cnt,
  output logic [SOL_W-1:0] sol_cnt
);

  localparam int unsigned WORDS = (VEC_W + 31) / 32;
  localparam int unsigned CW    = $clog2(WORDS) + 1;
  localparam int unsigned LW    = $clog2(CHK_LAT + 1) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'(CHK_LAT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GEN  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SOL  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]       state;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [VEC_W-1:0] cand_shift;
  logic [CW-1:0]    word_cnt;
  logic [LW-1:0]    lat_cnt;
  logic [TRY_W-1:0] tries_inc;
  logic [SOL_W-1:0] sol_inc;
  logic [SOL_W-1:0] sol_goal;
  logic             budget_spent;

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : '0);

  // Earlier words slide toward the MSBs so the first generated word ends on top.
  if (VEC_W > 32) begin : g_wide
    assign cand_shift = {cand_vec[VEC_W-33:0], lfsr_next};
  end else begin : g_narrow
    assign cand_shift = lfsr_next[VEC_W-1:0];
  end

  assign tries_inc    = (tries_cnt == '1) ? tries_cnt : tries_cnt + 1'b1;
  assign sol_inc      = (sol_cnt == '1) ? sol_cnt : sol_cnt + 1'b1;
  assign sol_goal     = (sol_target == '0) ? SOL_W'(1) : sol_target;
  assign budget_spent = (max_tries != '0) && (tries_cnt == max_tries);

  assign cand_valid = (state == S_WAIT);
  assign sol_valid  = (state == S_SOL);
  assign sol_vec    = cand_vec;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= 32'h1;
      cand_vec  <= '0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
      tries_cnt <= '0;
      sol_cnt   <= '0;
      found     <= 1'b0;
      timeout   <= 1'b0;
    end else if (abort) begin
      // A handshake coinciding with abort still counts the solution.
      state   <= S_IDLE;
      found   <= 1'b0;
      timeout <= 1'b0;
      if (state == S_SOL && sol_ready) sol_cnt <= sol_inc;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr      <= (seed == '0) ? 32'h1 : seed;
            tries_cnt <= '0;
            sol_cnt   <= '0;
            found     <= 1'b0;
            timeout   <= 1'b0;
            word_cnt  <= '0;
            state     <= S_GEN;
          end
        end
        S_GEN: begin
          lfsr     <= lfsr_next;
          cand_vec <= cand_shift;
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            lat_cnt  <= '0;
            state    <= S_WAIT;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAST_LAT) begin
            tries_cnt <= tries_inc;
            if (chk_result) begin
              state <= S_SOL;
            end else if (max_tries != '0 && tries_inc == max_tries) begin
              timeout <= 1'b1;
              state   <= S_FIN;
            end else begin
              state <= S_GEN;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_SOL: begin
          if (sol_ready) begin
            sol_cnt <= sol_inc;
            if (sol_inc == sol_goal) begin
              found <= 1'b1;
              state <= S_FIN;
            end else if (budget_spent) begin
              timeout <= 1'b1;
              state   <= S_FIN;
            end else begin
              state <= S_GEN;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_constraint_search_ctrl.sv
// Directed bench for constraint_search_ctrl: a 32-bit/latency-0 instance (a_) and a 64-bit/latency-2 instance (b_).
module tb_constraint_search_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic        a_start, a_abort, a_chk, a_rdy;
  logic [31:0] a_seed;
  logic [3:0]  a_max;
  logic [7:0]  a_tgt;
  logic [31:0] a_cand, a_svec;
  logic        a_cv, a_sv, a_busy, a_done, a_found, a_to;
  logic [3:0]  a_tries;
  logic [7:0]  a_sols;

  logic        b_start, b_abort, b_chk, b_rdy;
  logic [31:0] b_seed;
  logic [15:0] b_max;
  logic [7:0]  b_tgt;
  logic [63:0] b_cand, b_svec;
  logic        b_cv, b_sv, b_busy, b_done, b_found, b_to;
  logic [15:0] b_tries;
  logic [7:0]  b_sols;

  constraint_search_ctrl #(.VEC_W(32), .CHK_LAT(0), .TRY_W(4), .SOL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .seed(a_seed),
    .max_tries(a_max), .sol_target(a_tgt), .cand_vec(a_cand), .cand_valid(a_cv),
    .chk_result(a_chk), .sol_valid(a_sv), .sol_vec(a_svec), .sol_ready(a_rdy),
    .busy(a_busy), .done(a_done), .found(a_found), .timeout(a_to),
    .tries_cnt(a_tries), .sol_cnt(a_sols)
  );

  constraint_search_ctrl #(.VEC_W(64), .CHK_LAT(2), .TRY_W(16), .SOL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .seed(b_seed),
    .max_tries(b_max), .sol_target(b_tgt), .cand_vec(b_cand), .cand_valid(b_cv),
    .chk_result(b_chk), .sol_valid(b_sv), .sol_vec(b_svec), .sol_ready(b_rdy),
    .busy(b_busy), .done(b_done), .found(b_found), .timeout(b_to),
    .tries_cnt(b_tries), .sol_cnt(b_sols)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b_cand, b_cv, b_sv, b_svec, b_busy, b_done, b_found, b_to, b_tries, b_sols} !== '0) begin
      n_err++; $display("FAIL reset_b_outputs got nonzero, want all 0");
    end
    n_cmp++;
    if ({a_cand, a_cv, a_sv, a_busy, a_done, a_found, a_to, a_tries, a_sols} !== '0) begin
      n_err++; $display("FAIL reset_a_outputs got nonzero, want all 0");
    end
    #20 rst_n = 1'b1;
    clk_step();
    // Start a search on b and reset it while it is in WAIT.
    b_seed = 32'd5; b_chk = 1'b0; b_max = '0; b_tgt = 8'd1; b_rdy = 1'b0;
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    clk_step(); clk_step();
    n_cmp++;
    if (b_cv !== 1'b1) begin n_err++; $display("FAIL reset_pre_wait cand_valid got %b want 1", b_cv); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b_cand, b_cv, b_sv, b_svec, b_busy, b_done, b_found, b_to, b_tries, b_sols} !== '0) begin
      n_err++; $display("FAIL reset_mid_wait outputs got cand=%h busy=%b cv=%b want all 0", b_cand, b_busy, b_cv);
    end
    #3 rst_n = 1'b1;
    clk_step();
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    n_cmp++;
    if (b_busy !== 1'b1) begin n_err++; $display("FAIL reset_restart busy got %b want 1", b_busy); end
    b_abort = 1'b1; clk_step(); b_abort = 1'b0;
  endtask

  task automatic test_single_word();
    a_seed = 32'd1; a_chk = 1'b1; a_rdy = 1'b1; a_tgt = 8'd1; a_max = '0;
    a_start = 1'b1; clk_step(); a_start = 1'b0;
    clk_step();
    n_cmp++;
    if ({a_cv, a_sv} !== 2'b10) begin n_err++; $display("FAIL sw_wait cv/sv got %b%b want 10", a_cv, a_sv); end
    clk_step();
    n_cmp++;
    if (a_sv !== 1'b1 || a_svec !== 32'h80200003) begin
      n_err++; $display("FAIL sw_sol sv=%b vec=%h want 1 80200003", a_sv, a_svec);
    end
    n_cmp++;
    if (a_tries !== 4'd1) begin n_err++; $display("FAIL sw_tries got %0d want 1", a_tries); end
    clk_step();
    n_cmp++;
    if ({a_done, a_found, a_sv, a_to} !== 4'b1100 || a_sols !== 8'd1) begin
      n_err++; $display("FAIL sw_done done=%b found=%b sv=%b to=%b sols=%0d want 1 1 0 0 1", a_done, a_found, a_sv, a_to, a_sols);
    end
    clk_step();
    n_cmp++;
    if ({a_done, a_busy, a_found} !== 3'b001) begin
      n_err++; $display("FAIL sw_after done=%b busy=%b found=%b want 0 0 1", a_done, a_busy, a_found);
    end
  endtask

  task automatic test_target_zero();
    int k;
    a_seed = 32'd1; a_chk = 1'b1; a_rdy = 1'b1; a_tgt = 8'd0; a_max = '0;
    a_start = 1'b1; clk_step(); a_start = 1'b0;
    k = 0;
    while (!a_done && k < 20) begin clk_step(); k++; end
    n_cmp++;
    if (k !== 3 || a_found !== 1'b1 || a_sols !== 8'd1) begin
      n_err++; $display("FAIL tgt0 edges=%0d found=%b sols=%0d want 3 1 1", k, a_found, a_sols);
    end
    clk_step();
  endtask

  task automatic test_two_words_abort();
    int k;
    b_seed = 32'd0; b_chk = 1'b1; b_rdy = 1'b0; b_tgt = 8'd1; b_max = '0;
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    k = 0;
    while (!b_sv && k < 50) begin clk_step(); k++; end
    n_cmp++;
    if (k !== 5) begin n_err++; $display("FAIL tw_latency edges=%0d want 5", k); end
    n_cmp++;
    if (b_svec !== 64'h80200003_C0300002) begin
      n_err++; $display("FAIL tw_vec got %h want 80200003c0300002", b_svec);
    end
    b_abort = 1'b1; clk_step(); b_abort = 1'b0;
    n_cmp++;
    if ({b_busy, b_sv, b_cv, b_done, b_found, b_to} !== 6'b0 || b_sols !== 8'd0 || b_tries !== 16'd1) begin
      n_err++; $display("FAIL abort_sol busy=%b sv=%b done=%b sols=%0d tries=%0d want 0 0 0 0 1", b_busy, b_sv, b_done, b_sols, b_tries);
    end
    clk_step();
    n_cmp++;
    if (b_done !== 1'b0) begin n_err++; $display("FAIL abort_nodone done got %b want 0", b_done); end
    // Abort coinciding with a handshake: solution counted, still no done.
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    k = 0;
    while (!b_sv && k < 50) begin clk_step(); k++; end
    b_abort = 1'b1; b_rdy = 1'b1; clk_step(); b_abort = 1'b0; b_rdy = 1'b0;
    n_cmp++;
    if ({b_busy, b_done, b_found} !== 3'b000 || b_sols !== 8'd1) begin
      n_err++; $display("FAIL abort_hs busy=%b done=%b found=%b sols=%0d want 0 0 0 1", b_busy, b_done, b_found, b_sols);
    end
    clk_step();
    n_cmp++;
    if (b_done !== 1'b0) begin n_err++; $display("FAIL abort_hs_nodone done got %b want 0", b_done); end
  endtask

  task automatic test_timeout();
    int k;
    logic seen_sv;
    b_seed = 32'd7; b_chk = 1'b0; b_rdy = 1'b1; b_tgt = 8'd1; b_max = 16'd4;
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    k = 0; seen_sv = 1'b0;
    while (!b_done && k < 100) begin seen_sv |= b_sv; clk_step(); k++; end
    n_cmp++;
    if (k !== 20) begin n_err++; $display("FAIL to_edges got %0d want 20", k); end
    n_cmp++;
    if ({b_to, b_found, seen_sv} !== 3'b100 || b_tries !== 16'd4) begin
      n_err++; $display("FAIL to_flags to=%b found=%b sv_seen=%b tries=%0d want 1 0 0 4", b_to, b_found, seen_sv, b_tries);
    end
    clk_step();
    n_cmp++;
    if ({b_done, b_busy, b_to} !== 3'b001) begin
      n_err++; $display("FAIL to_after done=%b busy=%b to=%b want 0 0 1", b_done, b_busy, b_to);
    end
  endtask

  task automatic test_stall_multi();
    int k;
    logic stable;
    logic [63:0] v [3];
    b_seed = 32'h0000ACE1; b_chk = 1'b1; b_rdy = 1'b0; b_tgt = 8'd3; b_max = '0;
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      k = 0;
      while (!b_sv && k < 50) begin clk_step(); k++; end
      v[s] = b_svec;
      stable = b_sv;
      for (int c = 0; c < 10; c++) begin
        clk_step();
        if (b_sv !== 1'b1 || b_svec !== v[s]) stable = 1'b0;
      end
      n_cmp++;
      if (stable !== 1'b1) begin n_err++; $display("FAIL stall_stable sol=%0d vec=%h want held %h", s, b_svec, v[s]); end
      b_rdy = 1'b1; clk_step(); b_rdy = 1'b0;
      n_cmp++;
      if (b_sols !== 8'(s + 1)) begin n_err++; $display("FAIL stall_cnt got %0d want %0d", b_sols, s + 1); end
    end
    n_cmp++;
    if (v[0] === v[1] || v[1] === v[2] || v[0] === v[2]) begin
      n_err++; $display("FAIL stall_distinct %h %h %h want all different", v[0], v[1], v[2]);
    end
    n_cmp++;
    if ({b_done, b_found, b_to} !== 3'b110) begin
      n_err++; $display("FAIL stall_done done=%b found=%b to=%b want 1 1 0", b_done, b_found, b_to);
    end
    clk_step();
  endtask

  task automatic test_budget_after_sol();
    int k;
    b_seed = 32'd9; b_chk = 1'b1; b_rdy = 1'b1; b_tgt = 8'd2; b_max = 16'd1;
    b_start = 1'b1; clk_step(); b_start = 1'b0;
    k = 0;
    while (!b_done && k < 50) begin clk_step(); k++; end
    n_cmp++;
    if (k !== 6 || {b_to, b_found} !== 2'b10 || b_sols !== 8'd1 || b_tries !== 16'd1) begin
      n_err++; $display("FAIL budget_sol edges=%0d to=%b found=%b sols=%0d tries=%0d want 6 1 0 1 1", k, b_to, b_found, b_sols, b_tries);
    end
    clk_step();
  endtask

  task automatic test_saturation();
    a_seed = 32'd3; a_chk = 1'b0; a_rdy = 1'b0; a_tgt = 8'd1; a_max = '0;
    a_start = 1'b1; clk_step(); a_start = 1'b0;
    for (int c = 0; c < 40; c++) clk_step();
    n_cmp++;
    if (a_tries !== 4'hF || a_busy !== 1'b1) begin
      n_err++; $display("FAIL sat_tries tries=%0d busy=%b want 15 1", a_tries, a_busy);
    end
    a_abort = 1'b1; clk_step(); a_abort = 1'b0;
    n_cmp++;
    if (a_tries !== 4'hF || a_busy !== 1'b0) begin
      n_err++; $display("FAIL sat_abort tries=%0d busy=%b want 15 0", a_tries, a_busy);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    a_start = 1'b0; a_abort = 1'b0; a_chk = 1'b0; a_rdy = 1'b0; a_seed = '0; a_max = '0; a_tgt = '0;
    b_start = 1'b0; b_abort = 1'b0; b_chk = 1'b0; b_rdy = 1'b0; b_seed = '0; b_max = '0; b_tgt = '0;
    test_reset();
    test_single_word();
    test_target_zero();
    test_two_words_abort();
    test_timeout();
    test_stall_multi();
    test_budget_after_sol();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
